sram_ctrl: RTL



---
 rtl/sram_pkg.sv | 34 +++
 rtl/sram_wait_cnt.sv | 32 +++
 rtl/sram_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding, default geometry and timing for the async SRAM controller
package sram_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int DATA_W_DEF = 8;
  localparam int T_AS_DEF   = 1;
  localparam int T_WP_DEF   = 2;
  localparam int T_RD_DEF   = 2;
  localparam int T_TURN_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_SETUP = 3'd1,
    S_W_PULSE = 3'd2,
    S_W_HOLD  = 3'd3,
    S_R_WAIT  = 3'd4,
    S_TURN    = 3'd5
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // One spare bit so the largest timing value always fits.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    return $clog2(max4(a, b, c, d)) + 1;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// rtl/sram_wait_cnt.sv - loadable down-counter with done flag shared by all timed states
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       load load_val_i this cycle (state entry)
//   load_val_i   number of cycles the state lasts (>= 1)
//   done_o       high in the last cycle of the timed state
module sram_wait_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q > W'(1)) begin
      // Parks at 1 so an idle controller never wraps the counter.
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-request controller for an external 8-bit asynchronous SRAM
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake, accepted when both high at clk edge
//   req_we, req_addr, req_wdata     request type, address and write data
//   rd_valid, rd_data               one-cycle read completion pulse, data held until next read
//   wr_done                         one-cycle write completion pulse
//   sram_addr, sram_ce_n,
//   sram_we_n, sram_oe_n            registered SRAM control pins
//   sram_dq_oe, sram_dq_out,
//   sram_dq_in                      data pad output enable, outgoing and incoming data
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int T_AS   = T_AS_DEF,
  parameter int T_WP   = T_WP_DEF,
  parameter int T_RD   = T_RD_DEF,
  parameter int T_TURN = T_TURN_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_dq_oe,
  output logic [DATA_W-1:0] sram_dq_out,
  input  logic [DATA_W-1:0] sram_dq_in
);

  localparam int CNT_W = cnt_width(T_AS, T_WP, T_RD, T_TURN);

  state_e state_q, state_d;

  logic              accept;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_done;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ce_n_q, ce_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_done_q, wr_done_d;

  assign req_ready = (state_q == S_IDLE) & rst_n;
  assign accept    = req_valid & req_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = req_we ? S_W_SETUP : S_R_WAIT;
      S_W_SETUP: if (cnt_done) state_d = S_W_PULSE;
      S_W_PULSE: if (cnt_done) state_d = S_W_HOLD;
      S_W_HOLD:  state_d = S_IDLE;
      S_R_WAIT:  if (cnt_done) state_d = S_TURN;
      S_TURN:    if (cnt_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Counter is reloaded on every state change with the duration of the state being entered.
  always_comb begin
    cnt_load = (state_d != state_q);
    case (state_d)
      S_W_SETUP: cnt_val = CNT_W'(T_AS);
      S_W_PULSE: cnt_val = CNT_W'(T_WP);
      S_R_WAIT:  cnt_val = CNT_W'(T_RD);
      S_TURN:    cnt_val = CNT_W'(T_TURN);
      default:   cnt_val = CNT_W'(1);
    endcase
  end

  sram_wait_cnt #(
    .W(CNT_W)
  ) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  // Output logic: next values of the registered pins and completion flags
  always_comb begin
    addr_d     = addr_q;
    ce_n_d     = ce_n_q;
    we_n_d     = we_n_q;
    oe_n_d     = oe_n_q;
    dq_oe_d    = dq_oe_q;
    dq_out_d   = dq_out_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          ce_n_d = 1'b0;
          if (req_we) begin
            dq_out_d = req_wdata;
            dq_oe_d  = 1'b1;
          end else begin
            oe_n_d = 1'b0;
          end
        end
      end
      S_W_SETUP: if (cnt_done) we_n_d = 1'b0;
      S_W_PULSE: if (cnt_done) we_n_d = 1'b1;
      S_W_HOLD: begin
        // Data stays driven one cycle past the WEn rise for hold time.
        dq_oe_d   = 1'b0;
        ce_n_d    = 1'b1;
        wr_done_d = 1'b1;
      end
      S_R_WAIT: begin
        if (cnt_done) begin
          rd_data_d  = sram_dq_in;
          rd_valid_d = 1'b1;
          oe_n_d     = 1'b1;
          ce_n_d     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      ce_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
      dq_out_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      ce_n_q     <= ce_n_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      dq_oe_q    <= dq_oe_d;
      dq_out_q   <= dq_out_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
    end
  end

  assign sram_addr   = addr_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_dq_out = dq_out_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign wr_done     = wr_done_q;

endmodule
